// File: rtl/entity_loader_if.sv
// Host-side bundle of the entity loader: byte port, frame pulse, active entity words and status.
// master drives the host/sync side; slave is the loader itself.
interface entity_loader_if;
    logic [7:0]  data_in;
    logic        strobe_in;
    logic        frame_start;
    logic [13:0] entity_1;
    logic [13:0] entity_2;
    logic [13:0] entity_3;
    logic [13:0] entity_4;
    logic [13:0] entity_5;
    logic [13:0] entity_6;
    logic [13:0] entity_7;
    logic [13:0] entity_8;
    logic [13:0] entity_9;
    logic        busy;
    logic        pkt_err;
    logic        commit;

    modport master (
        output data_in, strobe_in, frame_start,
        input  entity_1, entity_2, entity_3, entity_4, entity_5,
        input  entity_6, entity_7, entity_8, entity_9,
        input  busy, pkt_err, commit
    );

    modport slave (
        input  data_in, strobe_in, frame_start,
        output entity_1, entity_2, entity_3, entity_4, entity_5,
        output entity_6, entity_7, entity_8, entity_9,
        output busy, pkt_err, commit
    );
endinterface

// File: rtl/entity_loader.sv
// Builds nine 14-bit entity words from 3-byte host packets into shadow registers and copies
// them to the active outputs on each frame_start, so a frame never shows a half-written scene.
module entity_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 250000,
    parameter logic [13:0] UNUSED_WORD    = 14'h3C00
) (
    input logic            clk,
    input logic            rst_n,
    entity_loader_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle,
        StGot0,
        StGot1
    } state_e;

    localparam logic [17:0] TimeoutLast = 18'(TIMEOUT_CYCLES - 1);

    logic        s1, s2, s3;
    logic        byte_stb;
    logic        timeout;
    state_e      state;
    logic [17:0] tmo_cnt;
    logic [3:0]  slot_q;
    logic [3:0]  id_q;
    logic [1:0]  orient_q;
    logic        busy_q;
    logic        pkt_err_q;
    logic        commit_q;
    logic [13:0] shadow [1:9];
    logic [13:0] active [1:9];

    // Three-flop synchroniser; the edge detect on s2/s3 yields one pulse per strobe rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= bus.strobe_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign byte_stb = s2 & ~s3;
    assign timeout  = (state != StIdle) && (tmo_cnt == TimeoutLast);

    // Packet FSM. Timeout wins over a coincident byte, which then starts a fresh packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            tmo_cnt   <= 18'd0;
            slot_q    <= 4'd0;
            id_q      <= 4'd0;
            orient_q  <= 2'd0;
            busy_q    <= 1'b0;
            pkt_err_q <= 1'b0;
            for (int i = 1; i <= 9; i++) begin
                shadow[i] <= UNUSED_WORD;
            end
        end else begin
            pkt_err_q <= 1'b0;

            if (byte_stb || timeout || state == StIdle) begin
                tmo_cnt <= 18'd0;
            end else begin
                tmo_cnt <= tmo_cnt + 18'd1;
            end

            if (timeout) begin
                pkt_err_q <= 1'b1;
                if (byte_stb) begin
                    slot_q <= bus.data_in[7:4];
                    id_q   <= bus.data_in[3:0];
                    state  <= StGot0;
                    busy_q <= 1'b1;
                end else begin
                    state  <= StIdle;
                    busy_q <= 1'b0;
                end
            end else if (byte_stb) begin
                unique case (state)
                    StIdle: begin
                        slot_q <= bus.data_in[7:4];
                        id_q   <= bus.data_in[3:0];
                        state  <= StGot0;
                        busy_q <= 1'b1;
                    end
                    StGot0: begin
                        orient_q <= bus.data_in[7:6];
                        state    <= StGot1;
                        busy_q   <= 1'b1;
                    end
                    StGot1: begin
                        state  <= StIdle;
                        busy_q <= 1'b0;
                        if (slot_q == 4'hF) begin
                            for (int i = 1; i <= 9; i++) begin
                                shadow[i] <= UNUSED_WORD;
                            end
                        end else if (slot_q >= 4'd1 && slot_q <= 4'd9) begin
                            for (int i = 1; i <= 9; i++) begin
                                if (slot_q == 4'(i)) begin
                                    shadow[i] <= {id_q, orient_q, bus.data_in};
                                end
                            end
                        end else begin
                            pkt_err_q <= 1'b1;
                        end
                    end
                    default: begin
                        state  <= StIdle;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Non-blocking copy picks up the shadows as they stood before this cycle's write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_q <= 1'b0;
            for (int i = 1; i <= 9; i++) begin
                active[i] <= UNUSED_WORD;
            end
        end else begin
            commit_q <= bus.frame_start;
            if (bus.frame_start) begin
                for (int i = 1; i <= 9; i++) begin
                    active[i] <= shadow[i];
                end
            end
        end
    end

    assign bus.entity_1 = active[1];
    assign bus.entity_2 = active[2];
    assign bus.entity_3 = active[3];
    assign bus.entity_4 = active[4];
    assign bus.entity_5 = active[5];
    assign bus.entity_6 = active[6];
    assign bus.entity_7 = active[7];
    assign bus.entity_8 = active[8];
    assign bus.entity_9 = active[9];
    assign bus.busy     = busy_q;
    assign bus.pkt_err  = pkt_err_q;
    assign bus.commit   = commit_q;

endmodule

// File: tb/tb_entity_loader.sv
// Randomised bench for entity_loader against a packet-level model of shadow/active slots.
module tb_entity_loader;

    localparam int unsigned TO = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    entity_loader_if bus ();

    entity_loader #(
        .TIMEOUT_CYCLES(TO),
        .UNUSED_WORD   (14'h3C00)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_pass = 0;
    int err_seen = 0;
    int commit_seen = 0;
    int err_exp = 0;
    int commit_exp = 0;
    logic [13:0] shadow_m [1:9];
    logic [13:0] active_m [1:9];
    logic [7:0]  pend [$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.pkt_err) err_seen++;
            if (bus.commit) commit_seen++;
        end
    end

    task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got 'h%0h, want 'h%0h", tag, obs, exp);
    endtask

    function automatic logic [13:0] dut_entity(input int i);
        case (i)
            1: return bus.entity_1;
            2: return bus.entity_2;
            3: return bus.entity_3;
            4: return bus.entity_4;
            5: return bus.entity_5;
            6: return bus.entity_6;
            7: return bus.entity_7;
            8: return bus.entity_8;
            default: return bus.entity_9;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 1; i <= 9; i++) begin
            shadow_m[i] = 14'h3C00;
            active_m[i] = 14'h3C00;
        end
        pend.delete();
    endtask

    task automatic model_frame();
        for (int i = 1; i <= 9; i++) active_m[i] = shadow_m[i];
        commit_exp++;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int slot;
        pend.push_back(b);
        if (pend.size() == 3) begin
            slot = int'(pend[0][7:4]);
            if (slot >= 1 && slot <= 9) shadow_m[slot] = {pend[0][3:0], pend[1][7:6], pend[2]};
            else if (slot == 15) for (int i = 1; i <= 9; i++) shadow_m[i] = 14'h3C00;
            else err_exp++;
            pend.delete();
        end
    endtask

    // The byte is acted on at the third rising edge after the strobe pin rises; an optional
    // frame_start is placed on exactly that edge.
    task automatic send_byte(input logic [7:0] b, input bit with_frame);
        @(negedge clk);
        bus.data_in = b;
        repeat (3) @(negedge clk);
        bus.strobe_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        if (with_frame) bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
        if (with_frame) model_frame();
        model_byte(b);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        bus.strobe_in = 1'b0;
        repeat (3) @(negedge clk);
        bus.data_in = 8'($urandom);
    endtask

    task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                               input bit frame_on_last);
        send_byte(b0, 1'b0);
        repeat ($urandom_range(0, 8)) @(negedge clk);
        send_byte(b1, 1'b0);
        repeat ($urandom_range(0, 8)) @(negedge clk);
        send_byte(b2, frame_on_last);
    endtask

    task automatic frame_pulse();
        @(negedge clk);
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
        model_frame();
        @(negedge clk);
    endtask

    task automatic wait_timeout();
        repeat (TO + 16) @(negedge clk);
        pend.delete();
        err_exp++;
    endtask

    task automatic check_all(input string tag);
        @(negedge clk);
        for (int i = 1; i <= 9; i++) begin
            check_val($sformatf("%s.entity_%0d", tag, i), dut_entity(i), active_m[i]);
        end
        check_val({tag, ".busy"}, bus.busy, (pend.size() != 0) ? 1 : 0);
        check_val({tag, ".pkt_err_cnt"}, err_seen, err_exp);
        check_val({tag, ".commit_cnt"}, commit_seen, commit_exp);
    endtask

    initial begin
        logic [7:0] b0, b1, b2;
        int r, slot;
        bus.data_in = 8'h00;
        bus.strobe_in = 1'b0;
        bus.frame_start = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        for (int i = 1; i <= 9; i++) check_val($sformatf("rst.entity_%0d", i), dut_entity(i), 14'h3C00);
        check_val("rst.busy", bus.busy, 0);
        check_val("rst.pkt_err", bus.pkt_err, 0);
        check_val("rst.commit", bus.commit, 0);
        rst_n = 1'b1;

        repeat (3) frame_pulse();
        check_all("idle_frames");

        send_packet(8'h35, 8'h80, 8'h2A, 1'b0);
        check_all("slot3_pre");
        frame_pulse();
        check_all("slot3_post");
        check_val("slot3_value", bus.entity_3, 14'h162A);

        send_byte(8'h35, 1'b0);
        send_byte(8'h80, 1'b0);
        check_val("partial_busy", bus.busy, 1);
        wait_timeout();
        check_all("timeout");
        send_packet(8'h91, 8'h40, 8'h07, 1'b0);
        frame_pulse();
        check_all("slot9");
        check_val("slot9_value", bus.entity_9, 14'h0507);

        send_packet(8'h02, 8'h00, 8'h10, 1'b0);
        frame_pulse();
        check_all("slot0_err");
        send_packet(8'h1A, 8'hC0, 8'h11, 1'b0);
        send_packet(8'h2B, 8'h40, 8'h22, 1'b0);
        frame_pulse();
        check_all("slot12");
        send_packet(8'hF0, 8'h00, 8'h00, 1'b0);
        frame_pulse();
        check_all("clear");
        check_val("clear_slot1", bus.entity_1, 14'h3C00);

        send_packet(8'h47, 8'hC0, 8'h5A, 1'b1);
        check_all("coinc_old");
        frame_pulse();
        check_all("coinc_new");

        send_byte(8'h35, 1'b0);
        send_byte(8'h80, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int i = 1; i <= 9; i++) check_val($sformatf("midrst.entity_%0d", i), dut_entity(i), 14'h3C00);
        check_val("midrst.busy", bus.busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_packet(8'h44, 8'hC0, 8'h99, 1'b0);
        frame_pulse();
        check_all("post_rst");

        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, 9);
            if (r < 7) slot = $urandom_range(1, 9);
            else if (r == 7) slot = 15;
            else slot = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(10, 14);
            b0 = {4'(slot), 4'($urandom)};
            b1 = 8'($urandom);
            b2 = 8'($urandom);
            if (r == 9) begin
                send_byte(b0, 1'b0);
                if ($urandom_range(0, 1) == 1) send_byte(b1, 1'b0);
                wait_timeout();
            end else begin
                send_packet(b0, b1, b2, $urandom_range(0, 4) == 0);
            end
            if ($urandom_range(0, 2) == 0) frame_pulse();
            check_all($sformatf("rand%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/entity_loader.md
Name: entity_loader

Overview:
- Upstream stage of the frame buffer controller: builds the nine 14-bit entity words (`[13:10]` ID, `[9:8]` orientation, `[7:0]` tile location) from a byte-wide host port on the dedicated inputs.
- Host writes go into shadow registers. All nine active outputs update together on a frame-start pulse, so the renderer never shows a half-written scene.
- Adds a strobe synchroniser, a 3-byte packet FSM with inter-byte timeout, slot decode and a clear-all command.

Parameters:
- TIMEOUT_CYCLES, 250000, max clk cycles between bytes of one packet before the FSM aborts (10 ms at 25 MHz); counter is 18 bits wide.
- UNUSED_WORD, 14'h3C00, value of an empty slot (ID 4'hF, orientation 0, location 0).

Ports:
- clk  input  1  pixel clock (25 MHz)
- rst_n  input  1  asynchronous active-low reset
- data_in  input  8  host byte; stable from 3 cycles before to 3 cycles after the strobe rising edge
- strobe_in  input  1  asynchronous host strobe; each rising edge delivers one byte
- frame_start  input  1  single-cycle pulse from the sync generator at the start of vertical blanking
- entity_1 … entity_9  output  14 each  active entity words to the frame buffer controller
- busy  output  1  high while a packet is partially received
- pkt_err  output  1  one-cycle pulse on a discarded packet (bad slot or timeout)
- commit  output  1  one-cycle pulse, one cycle after each shadow-to-active copy

Behaviour:
- Reset (async assert, sync release):
  - all active and shadow words = UNUSED_WORD.
  - FSM in IDLE; busy, pkt_err, commit = 0; synchroniser flops = 0; timeout counter = 0.
- Strobe synchroniser:
  - strobe_in passes through flops s1 → s2 → s3.
  - byte_stb = s2 & ~s3.
  - data_in is sampled in the byte_stb cycle.
  - Pin edge to capture: 2–3 cycles. A high-level hold produces exactly one byte.
- Packet format:
  - B0 = `{slot[3:0], id[3:0]}`.
  - B1 = `{orient[1:0], 6'b0}`; reserved bits are ignored.
  - B2 = location[7:0].
- FSM states and transitions:
  - IDLE: on byte_stb latch B0, go to GOT0.
  - GOT0: on byte_stb latch orient, go to GOT1.
  - GOT1: on byte_stb, write shadow and go to IDLE.
- Slot decode, evaluated on the B2 cycle:
  - slot 1–9: shadow[slot] ← `{id, orient, loc}`.
  - slot 4'hF: all nine shadows ← UNUSED_WORD; id, orient and loc are ignored.
  - slot 0 or 10–14: no write; pkt_err pulses the next cycle.
- Timeout:
  - counter clears on every byte_stb and increments in GOT0/GOT1.
  - reaching TIMEOUT_CYCLES in GOT0/GOT1 → IDLE, pkt_err pulse, no shadow write.
  - a byte_stb in the same cycle as the timeout is taken as a new B0.
- busy = (state != IDLE), registered with the state.
- Commit:
  - on frame_start, all active words ← shadow values as they stood before that cycle's update.
  - commit pulses the next cycle.
  - a shadow write in the same cycle as frame_start appears at the following frame_start.
  - a packet in progress does not block commit; its earlier bytes stay in FSM holding registers, never in the shadows.
- Active outputs change only on frame_start (or reset). Output latency from final byte to active word is up to one frame.
- Reset mid-packet: partial data is lost and all outputs return to reset values immediately (async).

Test Plan:
- Reset, no strobes, 3 frame_start pulses → all entity_n = 14'h3C00; commit pulses 3 times; busy and pkt_err stay 0.
- Packet 8'h35, 8'h80, 8'h2A, then frame_start → entity_3 = 14'h162A (ID 5, orient 2, loc 0x2A); other slots = 14'h3C00; entity_3 unchanged before frame_start.
- Bytes 8'h35, 8'h80, then a 250000-cycle gap → pkt_err pulse; busy falls. Next bytes 8'h91, 8'h40, 8'h07 → entity_9 = 14'h0507 after commit.
- Slot 0 packet 8'h02, 8'h00, 8'h10 → pkt_err pulse, no shadow change. Then clear packet 8'hF0, 8'h00, 8'h00 after loading slots 1 and 2 → all slots 14'h3C00 after commit.
- Final byte_stb coincident with frame_start → old entity_n value for that frame; new value after the next frame_start.
- Async rst_n low while in GOT1 → immediate reset values; first packet after release decodes correctly.
